stopwatch_sequencer: RTL

STOPWATCH_SEQUENCER -- requirements
Module: stopwatch_sequencer

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/stopwatch_sequencer_tick_gen.sv | 42 ++++
 rtl/stopwatch_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared mode encodings and widths for the stopwatch
package stopwatch_pkg;

  // 2-bit operating mode, driven straight onto the mode output
  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_ADJ_MIN = 2'b01,
    MODE_ADJ_SEC = 2'b10,
    MODE_PAUSED  = 2'b11
  } mode_e;

  localparam int CNT_W = 6;

  // True for the two adjust modes, where blink is active
  function automatic logic is_adjust(input mode_e m);
    return (m == MODE_ADJ_MIN) || (m == MODE_ADJ_SEC);
  endfunction

endpackage

// File: rtl/stopwatch_sequencer_tick_gen.sv
// rtl/stopwatch_sequencer_tick_gen.sv - free-running 2 Hz prescaler and 1 Hz derivation
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic res_n,
  output logic tick_2hz,
  output logic tick_1hz
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_phase;
  logic             w_div_last;

  assign w_div_last = (r_div_cnt == DIV_W'(TICK_DIV - 1));

  // Prescaler counts 0..TICK_DIV-1 and never restarts except on reset
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_div_cnt <= '0;
    end else if (w_div_last) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Phase flips on every 2 Hz tick so every second tick becomes the 1 Hz tick
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_phase <= 1'b0;
    end else if (w_div_last) begin
      r_phase <= ~r_phase;
    end
  end

  assign tick_2hz = w_div_last;
  assign tick_1hz = w_div_last & r_phase;

endmodule

// File: rtl/stopwatch_sequencer.sv
// rtl/stopwatch_sequencer.sv - mm:ss stopwatch with pause toggle and field adjust
module stopwatch_sequencer
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int MAX_COUNT = 59
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             pause_btn,
  input  logic             adj,
  input  logic             sel,
  output logic [CNT_W-1:0] minutes,
  output logic [CNT_W-1:0] seconds,
  output logic [1:0]       mode,
  output logic             blink
);

  logic [1:0]       r_pause_sync;
  logic [1:0]       r_adj_sync;
  logic [1:0]       r_sel_sync;
  logic             r_pause_prev;
  logic             r_paused;
  mode_e            r_state;
  mode_e            w_next_state;
  logic             w_press;
  logic             w_paused_next;
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_sec;
  logic             r_blink;
  logic             w_tick_2hz;
  logic             w_tick_1hz;
  logic             w_sec_max;
  logic             w_min_max;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .res_n   (res_n),
    .tick_2hz(w_tick_2hz),
    .tick_1hz(w_tick_1hz)
  );

  // Two-flop synchronizers for the asynchronous button and switches
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_pause_sync <= '0;
      r_adj_sync   <= '0;
      r_sel_sync   <= '0;
    end else begin
      r_pause_sync <= {r_pause_sync[0], pause_btn};
      r_adj_sync   <= {r_adj_sync[0], adj};
      r_sel_sync   <= {r_sel_sync[0], sel};
    end
  end

  // Rising edge of the synchronized button is a press, one cycle wide
  assign w_press       = r_pause_sync[1] & ~r_pause_prev;
  assign w_paused_next = r_paused ^ w_press;

  // Previous synchronized level for edge detection, and the pause toggle
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_pause_prev <= 1'b0;
      r_paused     <= 1'b0;
    end else begin
      r_pause_prev <= r_pause_sync[1];
      r_paused     <= w_paused_next;
    end
  end

  // Mode state register
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= MODE_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next mode: adjust switch dominates, otherwise the paused flag picks
  always_comb begin
    w_next_state = MODE_RUN;
    if (r_adj_sync[1]) begin
      w_next_state = r_sel_sync[1] ? MODE_ADJ_SEC : MODE_ADJ_MIN;
    end else if (w_paused_next) begin
      w_next_state = MODE_PAUSED;
    end
  end

  assign w_sec_max = (r_sec == CNT_W'(MAX_COUNT));
  assign w_min_max = (r_min == CNT_W'(MAX_COUNT));

  // Counters act on the mode already registered, so a same-cycle mode change waits a cycle
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_min <= '0;
      r_sec <= '0;
    end else begin
      unique case (r_state)
        MODE_RUN: begin
          if (w_tick_1hz) begin
            if (w_sec_max) begin
              r_sec <= '0;
              r_min <= w_min_max ? '0 : r_min + 1'b1;
            end else begin
              r_sec <= r_sec + 1'b1;
            end
          end
        end
        MODE_ADJ_MIN: begin
          if (w_tick_2hz) begin
            r_min <= w_min_max ? '0 : r_min + 1'b1;
          end
        end
        MODE_ADJ_SEC: begin
          if (w_tick_2hz) begin
            r_sec <= w_sec_max ? '0 : r_sec + 1'b1;
          end
        end
        MODE_PAUSED: begin
          r_min <= r_min;
          r_sec <= r_sec;
        end
      endcase
    end
  end

  // Blink toggles at 2 Hz while adjusting and is parked low otherwise
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_blink <= 1'b0;
    end else if (is_adjust(r_state)) begin
      if (w_tick_2hz) begin
        r_blink <= ~r_blink;
      end
    end else begin
      r_blink <= 1'b0;
    end
  end

  assign minutes = r_min;
  assign seconds = r_sec;
  assign mode    = r_state;
  // Gate so blink drops the same cycle the mode leaves adjust
  assign blink   = r_blink & is_adjust(r_state);

endmodule
